rotate_scan_ctrl: RTL and testbench

ROTATE_SCAN_CTRL -- requirements
Module: rotate_scan_ctrl

---
 rtl/rotate_scan_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_rotate_scan_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_scan_ctrl.sv
// rotate_scan_ctrl: raster scan generator that streams destination pixel
// coordinates and their rotated source coordinates with valid/ready flow.
// Rotation is about the frame centre (cols/2, rows/2). Coefficients are
// signed fixed point with ANGLE_WIDTH-2 fraction bits (1.0 = 2**(ANGLE_WIDTH-2)).
// Optional feature macro: ROTATE_SCAN_OOB_EN adds the out_oob flag.

module rotate_matrix #(
  parameter int unsigned IN_WIDTH    = 12,
  parameter int unsigned ANGLE_WIDTH = 10,
  parameter int unsigned OUT_WIDTH   = 14
) (
  input  logic [IN_WIDTH-1:0]    x,
  input  logic [IN_WIDTH-1:0]    y,
  input  logic [IN_WIDTH-1:0]    cols,
  input  logic [IN_WIDTH-1:0]    rows,
  input  logic [ANGLE_WIDTH-1:0] cos_theta,
  input  logic [ANGLE_WIDTH-1:0] sin_theta,
  output logic [OUT_WIDTH-1:0]   rot_x,
  output logic [OUT_WIDTH-1:0]   rot_y
);
  localparam int unsigned PW   = IN_WIDTH + ANGLE_WIDTH + 3;
  localparam int unsigned FRAC = ANGLE_WIDTH - 2;

  logic signed [PW-1:0] cx, cy, dx, dy, cs, sn, px, py;

  // Centre-relative rotation, arithmetic shift drops the fraction bits
  always_comb begin
    cx    = PW'(cols >> 1);
    cy    = PW'(rows >> 1);
    dx    = PW'(x) - cx;
    dy    = PW'(y) - cy;
    cs    = PW'($signed(cos_theta));
    sn    = PW'($signed(sin_theta));
    px    = ((dx * cs - dy * sn) >>> FRAC) + cx;
    py    = ((dx * sn + dy * cs) >>> FRAC) + cy;
    rot_x = OUT_WIDTH'(px);
    rot_y = OUT_WIDTH'(py);
  end
endmodule

module rotate_scan_ctrl #(
  parameter int unsigned IN_WIDTH    = 12,
  parameter int unsigned ANGLE_WIDTH = 10,
  parameter int unsigned OUT_WIDTH   = 14
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ANGLE_WIDTH-1:0] cos_theta,
  input  logic [ANGLE_WIDTH-1:0] sin_theta,
  input  logic [IN_WIDTH-1:0]    num_cols,
  input  logic [IN_WIDTH-1:0]    num_rows,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IN_WIDTH-1:0]    dst_x,
  output logic [IN_WIDTH-1:0]    dst_y,
  output logic [OUT_WIDTH-1:0]   src_x,
  output logic [OUT_WIDTH-1:0]   src_y,
  output logic                   out_sof,
  output logic                   out_eol,
  output logic                   out_eof,
`ifdef ROTATE_SCAN_OOB_EN
  output logic                   out_oob,
`endif
  output logic                   frame_done
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                 state, state_nxt;
  logic [ANGLE_WIDTH-1:0] cos_q, sin_q, cos_sel, sin_sel;
  logic [IN_WIDTH-1:0]    cols_q, rows_q, cols_sel, rows_sel;
  logic [IN_WIDTH-1:0]    nx, ny;
  logic [OUT_WIDTH-1:0]   rot_x, rot_y;
  logic                   latch, load, adv, accept;

  // Rotation of the coordinate about to be presented
  rotate_matrix #(
    .IN_WIDTH   (IN_WIDTH),
    .ANGLE_WIDTH(ANGLE_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_rot (
    .x        (nx),
    .y        (ny),
    .cols     (cols_sel),
    .rows     (rows_sel),
    .cos_theta(cos_sel),
    .sin_theta(sin_sel),
    .rot_x    (rot_x),
    .rot_y    (rot_y)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!resetb) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state, scan advance and operand selection (live inputs only on start)
  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    load      = 1'b0;
    adv       = 1'b0;
    nx        = dst_x;
    ny        = dst_y;
    cos_sel   = cos_q;
    sin_sel   = sin_q;
    cols_sel  = cols_q;
    rows_sel  = rows_q;
    accept    = out_valid && out_ready;
    case (state)
      ST_IDLE: begin
        if (start) begin
          latch    = 1'b1;
          cos_sel  = cos_theta;
          sin_sel  = sin_theta;
          cols_sel = num_cols;
          rows_sel = num_rows;
          if (num_cols != '0 && num_rows != '0) begin
            state_nxt = ST_RUN;
            load      = 1'b1;
            nx        = '0;
            ny        = '0;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (accept) begin
          if (out_eof) begin
            state_nxt = ST_DONE;
          end else begin
            adv = 1'b1;
            if (dst_x == cols_q - IN_WIDTH'(1)) begin
              nx = '0;
              ny = dst_y + IN_WIDTH'(1);
            end else begin
              nx = dst_x + IN_WIDTH'(1);
            end
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef ROTATE_SCAN_OOB_EN
  localparam int unsigned CW = OUT_WIDTH + IN_WIDTH + 1;
  logic signed [CW-1:0] sxe, sye, cole, rowe;
  logic                 oob_nxt;

  // Signed bounds test of the next source coordinate against the frame
  always_comb begin
    sxe     = CW'($signed(rot_x));
    sye     = CW'($signed(rot_y));
    cole    = CW'(cols_sel);
    rowe    = CW'(rows_sel);
    oob_nxt = (sxe < 0) || (sye < 0) || (sxe >= cole) || (sye >= rowe);
  end
`endif

  // Registered beat outputs, latched frame parameters and status flags
  always_ff @(posedge clk) begin
    if (!resetb) begin
      cos_q      <= '0;
      sin_q      <= '0;
      cols_q     <= '0;
      rows_q     <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      dst_x      <= '0;
      dst_y      <= '0;
      src_x      <= '0;
      src_y      <= '0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      out_eof    <= 1'b0;
`ifdef ROTATE_SCAN_OOB_EN
      out_oob    <= 1'b0;
`endif
    end else begin
      if (latch) begin
        cos_q  <= cos_theta;
        sin_q  <= sin_theta;
        cols_q <= num_cols;
        rows_q <= num_rows;
      end
      busy       <= (state_nxt != ST_IDLE);
      out_valid  <= (state_nxt == ST_RUN);
      frame_done <= (state_nxt == ST_DONE);
      if (load || adv) begin
        dst_x   <= nx;
        dst_y   <= ny;
        src_x   <= rot_x;
        src_y   <= rot_y;
        out_sof <= load;
        out_eol <= (nx == cols_sel - IN_WIDTH'(1));
        out_eof <= (nx == cols_sel - IN_WIDTH'(1)) && (ny == rows_sel - IN_WIDTH'(1));
`ifdef ROTATE_SCAN_OOB_EN
        out_oob <= oob_nxt;
`endif
      end else if (state_nxt != ST_RUN) begin
        out_sof <= 1'b0;
        out_eol <= 1'b0;
        out_eof <= 1'b0;
`ifdef ROTATE_SCAN_OOB_EN
        out_oob <= 1'b0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_rotate_scan_ctrl.sv
// Testbench for rotate_scan_ctrl: randomized frames checked against a
// behavioural beat-list model of the raster scan and centre rotation.
// Define ROTATE_SCAN_OOB_EN to also check out_oob.

module tb_rotate_scan_ctrl;
  localparam int IW = 12;
  localparam int AW = 10;
  localparam int OW = 14;
  localparam int BW = 2*IW + 2*OW + 3;

  logic          clk = 1'b0;
  logic          resetb, start, abort, out_ready;
  logic [AW-1:0] cos_theta, sin_theta;
  logic [IW-1:0] num_cols, num_rows;
  logic          busy, out_valid, out_sof, out_eol, out_eof, frame_done;
  logic [IW-1:0] dst_x, dst_y;
  logic [OW-1:0] src_x, src_y;
`ifdef ROTATE_SCAN_OOB_EN
  logic          out_oob;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rotate_scan_ctrl #(.IN_WIDTH(IW), .ANGLE_WIDTH(AW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .resetb(resetb), .start(start), .abort(abort),
    .cos_theta(cos_theta), .sin_theta(sin_theta),
    .num_cols(num_cols), .num_rows(num_rows),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .dst_x(dst_x), .dst_y(dst_y), .src_x(src_x), .src_y(src_y),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
`ifdef ROTATE_SCAN_OOB_EN
    .out_oob(out_oob),
`endif
    .frame_done(frame_done)
  );

  // Rotation about the frame centre, fixed point with 8 fraction bits
  function automatic int ref_x(int x, int y, int cols, int rows, int c, int s);
    int dx = x - cols / 2;
    int dy = y - rows / 2;
    return ((dx * c - dy * s) >>> 8) + cols / 2;
  endfunction

  function automatic int ref_y(int x, int y, int cols, int rows, int c, int s);
    int dx = x - cols / 2;
    int dy = y - rows / 2;
    return ((dx * s + dy * c) >>> 8) + rows / 2;
  endfunction

  // One frame: start, walk the expected beat list under a ready pattern,
  // then check the done pulse. mode 0: ready=1, 1: 1,0,0,1 pattern, 2: random
  task automatic run_frame(input int cols, input int rows, input logic [AW-1:0] c,
                           input logic [AW-1:0] s, input int mode, input bit mutate);
    int n, k, cyc, ex, ey, ci, si;
    bit rdy;
    bit pat [4];
    logic [OW-1:0] erx, ery;
    logic [BW-1:0] exp_b, got_b;
`ifdef ROTATE_SCAN_OOB_EN
    logic signed [OW-1:0] tx, ty;
    logic eoob;
`endif
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    n  = cols * rows;
    k  = 0;
    cyc = 0;
    ci = int'($signed(c));
    si = int'($signed(s));
    @(negedge clk);
    num_cols = IW'(cols); num_rows = IW'(rows);
    cos_theta = c; sin_theta = s; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (k < n && cyc < 1000) begin
      ex = k % cols;
      ey = k / cols;
      erx = OW'(ref_x(ex, ey, cols, rows, ci, si));
      ery = OW'(ref_y(ex, ey, cols, rows, ci, si));
      total++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
        bad++;
        $display("FAIL valid_busy beat=%0d got=%b%b exp=11", k, out_valid, busy);
      end
      exp_b = {IW'(ex), IW'(ey), erx, ery, (k == 0), (ex == cols - 1), (k == n - 1)};
      got_b = {dst_x, dst_y, src_x, src_y, out_sof, out_eol, out_eof};
      total++;
      if (got_b !== exp_b) begin
        bad++;
        $display("FAIL beat=%0d got=%h exp=%h", k, got_b, exp_b);
      end
`ifdef ROTATE_SCAN_OOB_EN
      tx = erx; ty = ery;
      eoob = (tx < 0) || (ty < 0) || (int'(tx) >= cols) || (int'(ty) >= rows);
      total++;
      if (out_oob !== eoob) begin
        bad++;
        $display("FAIL oob beat=%0d got=%b exp=%b", k, out_oob, eoob);
      end
`endif
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[cyc % 4];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (mutate && k == 3) begin
        cos_theta = ~c; sin_theta = c;
        num_cols = IW'(cols + 1); num_rows = IW'(rows + 2);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (rdy) k++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b0;
    total++;
    if (k != n) begin
      bad++;
      $display("FAIL frame_budget beats=%0d exp=%0d", k, n);
    end
    total++;
    if ({out_valid, busy, frame_done} !== 3'b011) begin
      bad++;
      $display("FAIL done_cycle got v/b/d=%b%b%b exp=011", out_valid, busy, frame_done);
    end
    @(negedge clk);
    total++;
    if ({out_valid, busy, frame_done} !== 3'b000) begin
      bad++;
      $display("FAIL after_done got v/b/d=%b%b%b exp=000", out_valid, busy, frame_done);
    end
  endtask

  task automatic test_reset;
    resetb = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    cos_theta = '0; sin_theta = '0; num_cols = '0; num_rows = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, busy, frame_done, out_sof, out_eol, out_eof} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=000000",
               {out_valid, busy, frame_done, out_sof, out_eol, out_eof});
    end
    total++;
    if ({dst_x, dst_y, src_x, src_y} !== '0) begin
      bad++;
      $display("FAIL reset_coords got=%h exp=0", {dst_x, dst_y, src_x, src_y});
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    resetb = 1'b1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_basic;
    run_frame(4, 3, 10'd256, 10'd0, 0, 1'b0);
    run_frame(4, 3, 10'd181, 10'd181, 0, 1'b0);
    run_frame(1, 1, 10'd256, 10'd0, 0, 1'b0);
    run_frame(4, 3, 10'd512, 10'd0, 0, 1'b0);
  endtask

  task automatic test_stall;
    run_frame(4, 3, 10'd221, 10'(-128), 1, 1'b0);
  endtask

  task automatic test_zero_dim;
    @(negedge clk);
    num_cols = '0; num_rows = IW'(5); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({out_valid, busy, frame_done} !== 3'b011) begin
      bad++;
      $display("FAIL zero_dim_done got v/b/d=%b%b%b exp=011", out_valid, busy, frame_done);
    end
    @(negedge clk);
    total++;
    if ({out_valid, busy, frame_done} !== 3'b000) begin
      bad++;
      $display("FAIL zero_dim_idle got v/b/d=%b%b%b exp=000", out_valid, busy, frame_done);
    end
  endtask

  task automatic test_abort;
    @(negedge clk);
    num_cols = IW'(4); num_rows = IW'(3); cos_theta = 10'd256; sin_theta = '0;
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if ({dst_x, dst_y} !== {IW'(0), IW'(1)}) begin
      bad++;
      $display("FAIL abort_beat5 got=(%0d,%0d) exp=(0,1)", dst_x, dst_y);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    out_ready = 1'b0;
    total++;
    if ({out_valid, busy, frame_done} !== 3'b000) begin
      bad++;
      $display("FAIL abort_exit got v/b/d=%b%b%b exp=000", out_valid, busy, frame_done);
    end
    @(negedge clk);
    total++;
    if (frame_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done got=%b exp=0", frame_done);
    end
    run_frame(4, 3, 10'd256, 10'd0, 0, 1'b0);
  endtask

  task automatic test_midframe_change;
    run_frame(4, 3, 10'd200, 10'(-160), 0, 1'b1);
    run_frame(3, 2, 10'(-256), 10'd64, 1, 1'b1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      run_frame(int'($urandom_range(1, 5)), int'($urandom_range(1, 4)),
                AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 1023)), 2, 1'b0);
    end
  endtask

  task automatic test_reset_midframe;
    @(negedge clk);
    num_cols = IW'(4); num_rows = IW'(3); cos_theta = 10'd300; sin_theta = 10'd50;
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    resetb = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, busy, frame_done, out_sof, out_eol, out_eof} !== 6'b0 ||
        {dst_x, dst_y, src_x, src_y} !== '0) begin
      bad++;
      $display("FAIL midframe_reset got=%b %h exp=0",
               {out_valid, busy, frame_done, out_sof, out_eol, out_eof},
               {dst_x, dst_y, src_x, src_y});
    end
    resetb = 1'b1;
    num_cols = IW'(2); num_rows = IW'(2); cos_theta = 10'd256; sin_theta = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    total++;
    if ({out_valid, busy, out_sof, dst_x, dst_y} !== {3'b111, IW'(0), IW'(0)}) begin
      bad++;
      $display("FAIL first_start got v/b/sof=%b%b%b dst=(%0d,%0d) exp=111 (0,0)",
               out_valid, busy, out_sof, dst_x, dst_y);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL cleanup_abort got=%b exp=0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_dim();
    test_abort();
    test_midframe_change();
    test_random();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
